mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (F stage) and data access (M stage) of the 5-stage RISC-V pipeline.
- Sequences multi-cycle memory transactions with a req/ready handshake.
- Generates the stall and bubble controls (StallF, StallD, StallE, StallM, FlushW) that freeze the pipeline while an access is outstanding.
- Keeps a stall-cycle performance counter.

Parameters:
- XLEN, 32, data/address width.
- DATA_FIRST, 1, when 1 a pending data access wins over a pending fetch in IDLE; when 0 fetch wins.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- PCF  in  XLEN  fetch address.
- InstrF  out  XLEN  fetched instruction for PCF.
- ALUResultM  in  XLEN  data address.
- WriteDataM  in  XLEN  store data.
- MemWriteM  in  1  store in M stage.
- MemReadM  in  1  load in M stage.
- ReadDataM  out  XLEN  load data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write enable, registered.
- mem_addr  out  XLEN  registered.
- mem_wdata  out  XLEN  registered.
- mem_rdata  in  XLEN  memory read data, valid with mem_ready.
- mem_ready  in  1  transaction complete this cycle.
- StallF, StallD, StallE, StallM  out  1 each  pipeline register hold enables (active-high).
- FlushW  out  1  insert bubble into M/W register.
- stall_cycles  out  32  count of cycles with StallF=1.

Behaviour:
- States: IDLE, IWAIT, DWAIT.
- Internal registers:
  - ibuf, itag (XLEN), ivalid.
  - dbuf (XLEN), ddone.
  - pc_q (address of the in-flight fetch).
- Hit and completion terms:
  - ihit = (ivalid & itag==PCF) | (state==IWAIT & mem_ready & pc_q==PCF).
  - dpend = (MemReadM|MemWriteM) & ~ddone & ~(state==DWAIT & mem_ready).
- Combinational outputs:
  - StallE = StallM = FlushW = dpend.
  - StallF = StallD = dpend | ~ihit.
  - InstrF = mem_rdata when state==IWAIT & mem_ready, else ibuf.
  - ReadDataM = mem_rdata when state==DWAIT & mem_ready, else dbuf.
- IDLE transitions, with data needed = (MemReadM|MemWriteM) & ~ddone and fetch needed = ~ihit:
  - Only one needed: go DWAIT or IWAIT respectively.
  - Both needed: DATA_FIRST selects which.
  - Neither needed: stay in IDLE.
  - On entering DWAIT: next edge drives mem_req=1, mem_we=MemWriteM, mem_addr=ALUResultM, mem_wdata=WriteDataM.
  - On entering IWAIT: mem_we=0, mem_addr=PCF, pc_q=PCF.
- IWAIT/DWAIT: mem_req and mem_* are held stable until mem_ready=1. mem_ready may arrive in the first req cycle.
  - On mem_ready in IWAIT: ibuf=mem_rdata, itag=pc_q, ivalid=1, mem_req=0, go IDLE.
  - On mem_ready in DWAIT: dbuf=mem_rdata (stores too, value unused), ddone=1, mem_req=0, go IDLE.
- ddone clears on any edge where StallM=0, i.e. the M instruction leaves. Setting takes precedence when both occur in the same cycle.
- Redirect (PCF changes while IWAIT): the in-flight fetch completes, is tagged with the stale pc_q, fails ihit, and a refetch follows. A transaction is never aborted except by reset.
- Minimum latency: fetch miss costs 1 IDLE cycle + memory latency. With ready in the first req cycle, StallF is low in the second cycle.
- stall_cycles increments each cycle StallF=1 and wraps at 2^32.
- Reset (also mid-transaction): on the next edge state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ivalid=0, ddone=0, ibuf=dbuf=0, stall_cycles=0.
  - The memory must tolerate an abandoned request.
  - After reset StallF=StallD=1 until the first fetch completes.
- mem_ready outside IWAIT/DWAIT is ignored.

Decomposition:
- Package riscv_mem_pkg: typedef enum logic [1:0] {IDLE, IWAIT, DWAIT} mem_arb_state_t; XLEN default constant.
- No sub-module required. The perf counter is inline.

Test Plan:
- Reset release, PCF=0x0, memory returns 0x00500093 with ready 1 cycle after req → mem_req rises 1 cycle after reset drop; InstrF=0x00500093 and StallF=0 in the ready cycle; stall_cycles=2.
- Fetch of 0x4 pending plus load MemReadM=1, ALUResultM=0x100, memory latency 3, DATA_FIRST=1 → data request first with mem_addr=0x100, mem_we=0. StallM/FlushW high until ready, ReadDataM equals mem_rdata; then fetch of 0x4 issues.
- Store MemWriteM=1, addr 0x200, data 0xDEADBEEF → mem_we=1, mem_wdata=0xDEADBEEF held stable across a 4-cycle wait; single transaction only; ddone clears when StallM drops.
- PCF changes 0x8→0x40 during IWAIT for 0x8 → first completion does not release StallF; second request with mem_addr=0x40 follows; InstrF matches the data for 0x40.
- Reset asserted in DWAIT with ready never given → next cycle mem_req=0, state IDLE, stall_cycles=0, StallF=1.
- DATA_FIRST=0 with simultaneous needs → fetch issued first, data second.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package riscv_mem_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2
  } mem_arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates F-stage fetch and M-stage load/store onto one single-port memory; a miss costs 1 IDLE cycle plus memory
// latency. The pipeline is held through StallF/D/E/M and FlushW while the memory withholds mem_ready.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrF,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushW,
  output logic [31:0]     stall_cycles
);

  mem_arb_state_t  state;
  logic [XLEN-1:0] ibuf;
  logic [XLEN-1:0] itag;
  logic [XLEN-1:0] dbuf;
  logic [XLEN-1:0] pcQ;
  logic            ivalid;
  logic            ddone;

  logic iwaitDone;
  logic dwaitDone;
  logic ihit;
  logic dataNeed;
  logic fetchNeed;
  logic dpend;

  assign iwaitDone = (state == IWAIT) && mem_ready;
  assign dwaitDone = (state == DWAIT) && mem_ready;

  // A completing fetch only counts as a hit if PCF has not been redirected meanwhile.
  assign ihit      = (ivalid && (itag == PCF)) || (iwaitDone && (pcQ == PCF));
  assign dataNeed  = (MemReadM || MemWriteM) && !ddone;
  assign fetchNeed = !ihit;
  assign dpend     = dataNeed && !dwaitDone;

  assign StallE = dpend;
  assign StallM = dpend;
  assign FlushW = dpend;
  assign StallF = dpend || !ihit;
  assign StallD = dpend || !ihit;

  assign InstrF    = iwaitDone ? mem_rdata : ibuf;
  assign ReadDataM = dwaitDone ? mem_rdata : dbuf;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ibuf         <= '0;
      itag         <= '0;
      ivalid       <= 1'b0;
      dbuf         <= '0;
      ddone        <= 1'b0;
      pcQ          <= '0;
      stall_cycles <= '0;
    end else begin
      if (StallF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end

      // Completion wins over the M instruction leaving in the same cycle.
      if (dwaitDone) begin
        ddone <= 1'b1;
      end else if (!StallM) begin
        ddone <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (dataNeed && (DATA_FIRST || !fetchNeed)) begin
            state     <= DWAIT;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= ALUResultM;
            mem_wdata <= WriteDataM;
          end else if (fetchNeed) begin
            state    <= IWAIT;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= PCF;
            pcQ      <= PCF;
          end
        end
        IWAIT: begin
          if (mem_ready) begin
            ibuf    <= mem_rdata;
            itag    <= pcQ;
            ivalid  <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        DWAIT: begin
          if (mem_ready) begin
            dbuf    <= mem_rdata;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut uses data-first priority, dut0 fetch-first; the bench plays the memory
// and pipeline by hand.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rst0;
  logic [31:0] PCF, ALUResultM, WriteDataM;
  logic        MemWriteM, MemReadM;

  logic [31:0] InstrF, ReadDataM, mem_addr, mem_wdata, mem_rdata, stall_cycles;
  logic        mem_req, mem_we, mem_ready, StallF, StallD, StallE, StallM, FlushW;

  logic [31:0] InstrF0, ReadDataM0, mem_addr0, mem_wdata0, mem_rdata0, stall_cycles0;
  logic        mem_req0, mem_we0, mem_ready0, StallF0, StallD0, StallE0, StallM0, FlushW0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .InstrF(InstrF), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ReadDataM(ReadDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushW(FlushW), .stall_cycles(stall_cycles)
  );

  mem_port_arbiter #(.XLEN(32), .DATA_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .PCF(PCF), .InstrF(InstrF0), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ReadDataM(ReadDataM0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .mem_ready(mem_ready0), .StallF(StallF0), .StallD(StallD0),
    .StallE(StallE0), .StallM(StallM0), .FlushW(FlushW0), .stall_cycles(stall_cycles0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got=%0h exp=0", mem_req); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got=%0h exp=0", mem_addr); end
    vectors++; if (stall_cycles !== 32'h0) begin miscompares++; $display("FAIL rst_cnt got=%0d exp=0", stall_cycles); end
    vectors++; if (StallF !== 1'b1) begin miscompares++; $display("FAIL rst_stallf got=%0h exp=1", StallF); end
    vectors++; if (InstrF !== 32'h0) begin miscompares++; $display("FAIL rst_instr got=%0h exp=0", InstrF); end
    reset = 1'b0;
    #1;
    vectors++; if (StallD !== 1'b1) begin miscompares++; $display("FAIL c0_stalld got=%0h exp=1", StallD); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL c0_req got=%0h exp=0", mem_req); end
  endtask

  task automatic test_first_fetch;
    tick;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ff_req got=%0h exp=1", mem_req); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL ff_addr got=%0h exp=0", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL ff_we got=%0h exp=0", mem_we); end
    vectors++; if (StallF !== 1'b1) begin miscompares++; $display("FAIL ff_wait_stallf got=%0h exp=1", StallF); end
    tick;
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    #1;
    vectors++; if (InstrF !== 32'h00500093) begin miscompares++; $display("FAIL ff_instr got=%0h exp=00500093", InstrF); end
    vectors++; if (StallF !== 1'b0) begin miscompares++; $display("FAIL ff_stallf got=%0h exp=0", StallF); end
    vectors++; if (stall_cycles !== 32'd2) begin miscompares++; $display("FAIL ff_cnt got=%0d exp=2", stall_cycles); end
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL ff_req_drop got=%0h exp=0", mem_req); end
    vectors++; if (StallF !== 1'b0) begin miscompares++; $display("FAIL ff_hit got=%0h exp=0", StallF); end
    vectors++; if (InstrF !== 32'h00500093) begin miscompares++; $display("FAIL ff_ibuf got=%0h exp=00500093", InstrF); end
  endtask

  task automatic test_load_priority;
    PCF = 32'h4; MemReadM = 1'b1; ALUResultM = 32'h100;
    #1;
    vectors++; if (StallM !== 1'b1) begin miscompares++; $display("FAIL ld_stallm got=%0h exp=1", StallM); end
    vectors++; if (FlushW !== 1'b1) begin miscompares++; $display("FAIL ld_flushw got=%0h exp=1", FlushW); end
    vectors++; if (StallE !== 1'b1) begin miscompares++; $display("FAIL ld_stalle got=%0h exp=1", StallE); end
    tick;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ld_req got=%0h exp=1", mem_req); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL ld_addr got=%0h exp=100", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL ld_we got=%0h exp=0", mem_we); end
    tick;
    vectors++; if (StallM !== 1'b1) begin miscompares++; $display("FAIL ld_wait_stallm got=%0h exp=1", StallM); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL ld_wait_addr got=%0h exp=100", mem_addr); end
    tick;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL ld_done_stallm got=%0h exp=0", StallM); end
    vectors++; if (FlushW !== 1'b0) begin miscompares++; $display("FAIL ld_done_flushw got=%0h exp=0", FlushW); end
    vectors++; if (ReadDataM !== 32'h12345678) begin miscompares++; $display("FAIL ld_rdata got=%0h exp=12345678", ReadDataM); end
    vectors++; if (StallF !== 1'b1) begin miscompares++; $display("FAIL ld_fetch_pending got=%0h exp=1", StallF); end
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0; MemReadM = 1'b0;
    #1;
    vectors++; if (ReadDataM !== 32'h12345678) begin miscompares++; $display("FAIL ld_dbuf got=%0h exp=12345678", ReadDataM); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL ld_req_drop got=%0h exp=0", mem_req); end
    tick;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ld_fetch_req got=%0h exp=1", mem_req); end
    vectors++; if (mem_addr !== 32'h4) begin miscompares++; $display("FAIL ld_fetch_addr got=%0h exp=4", mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h00000013;
    #1;
    vectors++; if (InstrF !== 32'h00000013) begin miscompares++; $display("FAIL ld_fetch_instr got=%0h exp=13", InstrF); end
    vectors++; if (StallF !== 1'b0) begin miscompares++; $display("FAIL ld_fetch_stallf got=%0h exp=0", StallF); end
    tick;
    mem_ready = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL ld_fetch_drop got=%0h exp=0", mem_req); end
  endtask

  task automatic test_store;
    MemWriteM = 1'b1; ALUResultM = 32'h200; WriteDataM = 32'hDEADBEEF;
    #1;
    vectors++; if (StallM !== 1'b1) begin miscompares++; $display("FAIL st_stallm got=%0h exp=1", StallM); end
    tick;
    WriteDataM = 32'h0; ALUResultM = 32'h204;
    #1;
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL st_we got=%0h exp=1", mem_we); end
    vectors++; if (mem_addr !== 32'h200) begin miscompares++; $display("FAIL st_addr got=%0h exp=200", mem_addr); end
    vectors++; if (mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL st_wdata got=%0h exp=deadbeef", mem_wdata); end
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL st_hold_req[%0d] got=%0h exp=1", i, mem_req); end
      vectors++; if (mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL st_hold_wdata[%0d] got=%0h exp=deadbeef", i, mem_wdata); end
      vectors++; if (mem_addr !== 32'h200) begin miscompares++; $display("FAIL st_hold_addr[%0d] got=%0h exp=200", i, mem_addr); end
      vectors++; if (StallM !== 1'b1) begin miscompares++; $display("FAIL st_hold_stallm[%0d] got=%0h exp=1", i, StallM); end
    end
    tick;
    mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
    #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL st_done_stallm got=%0h exp=0", StallM); end
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL st_single got=%0h exp=0", mem_req); end
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL st_ddone got=%0h exp=0", StallM); end
    vectors++; if (ReadDataM !== 32'h55AA55AA) begin miscompares++; $display("FAIL st_dbuf got=%0h exp=55aa55aa", ReadDataM); end
    tick;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL st_no_reissue got=%0h exp=0", mem_req); end
    vectors++; if (StallM !== 1'b1) begin miscompares++; $display("FAIL st_ddone_clr got=%0h exp=1", StallM); end
    MemWriteM = 1'b0;
    tick;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL st_idle got=%0h exp=0", mem_req); end
  endtask

  task automatic test_redirect;
    PCF = 32'h8;
    #1;
    vectors++; if (StallF !== 1'b1) begin miscompares++; $display("FAIL rd_miss got=%0h exp=1", StallF); end
    tick;
    vectors++; if (mem_addr !== 32'h8) begin miscompares++; $display("FAIL rd_addr8 got=%0h exp=8", mem_addr); end
    PCF = 32'h40;
    tick;
    mem_ready = 1'b1; mem_rdata = 32'hAAAA0008;
    #1;
    vectors++; if (StallF !== 1'b1) begin miscompares++; $display("FAIL rd_stale_stallf got=%0h exp=1", StallF); end
    vectors++; if (mem_addr !== 32'h8) begin miscompares++; $display("FAIL rd_hold_addr got=%0h exp=8", mem_addr); end
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rd_idle got=%0h exp=0", mem_req); end
    vectors++; if (StallF !== 1'b1) begin miscompares++; $display("FAIL rd_tag_miss got=%0h exp=1", StallF); end
    tick;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rd_refetch_req got=%0h exp=1", mem_req); end
    vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("FAIL rd_refetch_addr got=%0h exp=40", mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h0400006F;
    #1;
    vectors++; if (InstrF !== 32'h0400006F) begin miscompares++; $display("FAIL rd_instr got=%0h exp=0400006f", InstrF); end
    vectors++; if (StallF !== 1'b0) begin miscompares++; $display("FAIL rd_stallf got=%0h exp=0", StallF); end
    tick;
    mem_ready = 1'b0;
    #1;
    vectors++; if (StallF !== 1'b0) begin miscompares++; $display("FAIL rd_hit got=%0h exp=0", StallF); end
  endtask

  task automatic test_stray_ready;
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    vectors++; if (InstrF !== 32'h0400006F) begin miscompares++; $display("FAIL sr_instr got=%0h exp=0400006f", InstrF); end
    vectors++; if (ReadDataM !== 32'h55AA55AA) begin miscompares++; $display("FAIL sr_rdata got=%0h exp=55aa55aa", ReadDataM); end
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL sr_req got=%0h exp=0", mem_req); end
    vectors++; if (InstrF !== 32'h0400006F) begin miscompares++; $display("FAIL sr_ibuf got=%0h exp=0400006f", InstrF); end
  endtask

  task automatic test_reset_mid;
    MemReadM = 1'b1; ALUResultM = 32'h300;
    tick;
    vectors++; if (mem_addr !== 32'h300) begin miscompares++; $display("FAIL rm_addr got=%0h exp=300", mem_addr); end
    reset = 1'b1;
    tick;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rm_req got=%0h exp=0", mem_req); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rm_addr0 got=%0h exp=0", mem_addr); end
    vectors++; if (stall_cycles !== 32'h0) begin miscompares++; $display("FAIL rm_cnt got=%0d exp=0", stall_cycles); end
    vectors++; if (StallF !== 1'b1) begin miscompares++; $display("FAIL rm_stallf got=%0h exp=1", StallF); end
    vectors++; if (ReadDataM !== 32'h0) begin miscompares++; $display("FAIL rm_dbuf got=%0h exp=0", ReadDataM); end
    reset = 1'b0; MemReadM = 1'b0;
    tick;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rm_refetch_req got=%0h exp=1", mem_req); end
    vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("FAIL rm_refetch_addr got=%0h exp=40", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rm_refetch_we got=%0h exp=0", mem_we); end
  endtask

  task automatic test_fetch_first;
    reset = 1'b1;
    PCF = 32'h10; MemReadM = 1'b1; ALUResultM = 32'h180; WriteDataM = 32'h0;
    tick;
    rst0 = 1'b0;
    #1;
    vectors++; if (mem_req0 !== 1'b0) begin miscompares++; $display("FAIL f0_req got=%0h exp=0", mem_req0); end
    vectors++; if (StallD0 !== 1'b1) begin miscompares++; $display("FAIL f0_stalld got=%0h exp=1", StallD0); end
    vectors++; if (StallE0 !== 1'b1) begin miscompares++; $display("FAIL f0_stalle got=%0h exp=1", StallE0); end
    vectors++; if (FlushW0 !== 1'b1) begin miscompares++; $display("FAIL f0_flushw got=%0h exp=1", FlushW0); end
    tick;
    vectors++; if (mem_addr0 !== 32'h10) begin miscompares++; $display("FAIL f0_fetch_first got=%0h exp=10", mem_addr0); end
    vectors++; if (mem_we0 !== 1'b0) begin miscompares++; $display("FAIL f0_we got=%0h exp=0", mem_we0); end
    vectors++; if (mem_wdata0 !== 32'h0) begin miscompares++; $display("FAIL f0_wdata got=%0h exp=0", mem_wdata0); end
    vectors++; if (stall_cycles0 !== 32'd1) begin miscompares++; $display("FAIL f0_cnt got=%0d exp=1", stall_cycles0); end
    mem_ready0 = 1'b1; mem_rdata0 = 32'h11111111;
    #1;
    vectors++; if (InstrF0 !== 32'h11111111) begin miscompares++; $display("FAIL f0_instr got=%0h exp=11111111", InstrF0); end
    vectors++; if (StallF0 !== 1'b1) begin miscompares++; $display("FAIL f0_stallf_dpend got=%0h exp=1", StallF0); end
    vectors++; if (StallM0 !== 1'b1) begin miscompares++; $display("FAIL f0_stallm got=%0h exp=1", StallM0); end
    tick;
    mem_ready0 = 1'b0; mem_rdata0 = 32'h0;
    #1;
    vectors++; if (mem_req0 !== 1'b0) begin miscompares++; $display("FAIL f0_idle got=%0h exp=0", mem_req0); end
    tick;
    vectors++; if (mem_addr0 !== 32'h180) begin miscompares++; $display("FAIL f0_data_second got=%0h exp=180", mem_addr0); end
    mem_ready0 = 1'b1; mem_rdata0 = 32'h22222222;
    #1;
    vectors++; if (ReadDataM0 !== 32'h22222222) begin miscompares++; $display("FAIL f0_rdata got=%0h exp=22222222", ReadDataM0); end
    vectors++; if (StallM0 !== 1'b0) begin miscompares++; $display("FAIL f0_stallm_done got=%0h exp=0", StallM0); end
    tick;
    mem_ready0 = 1'b0; MemReadM = 1'b0;
    #1;
    vectors++; if (mem_req0 !== 1'b0) begin miscompares++; $display("FAIL f0_end got=%0h exp=0", mem_req0); end
  endtask

  initial begin
    reset = 1'b1; rst0 = 1'b1;
    PCF = 32'h0; ALUResultM = 32'h0; WriteDataM = 32'h0;
    MemWriteM = 1'b0; MemReadM = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    mem_ready0 = 1'b0; mem_rdata0 = 32'h0;
    tick;
    tick;
    test_reset;
    test_first_fetch;
    test_load_priority;
    test_store;
    test_redirect;
    test_stray_ready;
    test_reset_mid;
    test_fetch_first;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
